// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO stream reader: defaults, beat index sizing and
// the stream beat payload.
package fifo_stream_reader_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BURST_LEN_DEF = 4;
    localparam int unsigned CNT_W_DEF     = 32;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    // Beat index width; a one-beat burst still needs a 1-bit index register.
    function automatic int unsigned idx_w(input int unsigned len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry in-order valid/ready buffer; the head entry drives the output and the
// occupancy is exported so the reader can throttle FIFO reads.
module stream_skid_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_in_valid,
    input  logic [W-1:0] i_in_data,
    input  logic         i_out_ready,
    output logic         o_out_valid,
    output logic [W-1:0] o_out_data,
    output logic [1:0]   o_occ
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_occ;
    logic         w_pop;

    assign w_pop = (r_occ != 2'd0) && i_out_ready;

    // Writes land in the first free slot; a pop shifts the tail into the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({i_in_valid, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_head <= i_in_data;
                    else               r_tail <= i_in_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_in_data;
                    end else begin
                        r_head <= i_in_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_out_valid = (r_occ != 2'd0);
    assign o_out_data  = r_head;
    assign o_occ       = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: issues reads, absorbs the one-cycle
// read latency and presents a valid/ready stream grouped into fixed-length bursts.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned WIDTH     = DATA_W,
    parameter int unsigned BURST_LEN = BURST_LEN_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] beat_total
);

    localparam int unsigned       IDX_W    = idx_w(BURST_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BURST_LEN - 1);

    logic             r_inflight;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_total;
    logic [1:0]       w_occ;
    logic             w_pop;
    logic [2:0]       w_level;
    logic             w_room;
    logic             w_at_last;

    stream_skid_buf #(.W(WIDTH)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (r_inflight),
        .i_in_data   (fifo_data),
        .i_out_ready (m_ready),
        .o_out_valid (m_valid),
        .o_out_data  (m_data),
        .o_occ       (w_occ)
    );

    assign w_pop     = m_valid && m_ready;
    assign w_at_last = (r_idx == LAST_IDX);

    // Issue only if buffered + inflight words, less this cycle's pop, leave a slot.
    assign w_level    = 3'(w_occ) + 3'(r_inflight);
    assign w_room     = w_level < (3'd2 + 3'(w_pop));
    assign fifo_rd_en = enable && !fifo_empty && !rst && w_room;

    assign m_last     = m_valid && w_at_last;
    assign beat_total = r_total;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_idx      <= '0;
            r_total    <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_pop) begin
                r_total <= r_total + CNT_W'(1);
                r_idx   <= w_at_last ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model with one-cycle read latency, a queue
// model of issued-but-unaccepted words, and directed burst scenarios.
module tb_fifo_stream_reader;
    import fifo_stream_reader_pkg::*;

    localparam int unsigned BL = 4;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } ent_t;

    typedef struct {
        beat_t       b;
        int unsigned cyc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst, enable, m_ready, fifo_clr;
    logic        fifo_empty;
    logic [31:0] fifo_data = '0;
    logic        fifo_rd_en, m_valid, m_last;
    logic [31:0] m_data, beat_total;
    logic        fifo_rd_en1, m_valid1, m_last1;
    logic [31:0] m_data1, beat_total1;

    logic [31:0] fmem [256];
    int unsigned wp = 0;
    int unsigned rp = 0;

    ent_t        q[$];
    rec_t        log_q[$];
    int unsigned pops = 0;
    int unsigned cyc = 0;
    bit          mdl_ok = 1'b0;
    int          ntests = 0;
    int          nfail = 0;
    int unsigned c0;
    bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(32), .BURST_LEN(BL), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .beat_total(beat_total)
    );

    fifo_stream_reader #(.WIDTH(32), .BURST_LEN(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en1), .fifo_data(fifo_data), .m_valid(m_valid1),
        .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1), .beat_total(beat_total1)
    );

    // FIFO model: data_out follows an accepted read by one cycle.
    assign fifo_empty = (wp == rp);
    always @(posedge clk) begin
        if (fifo_clr) begin
            rp <= wp;
        end else if (fifo_rd_en && (wp != rp)) begin
            fifo_data <= fmem[rp[7:0]];
            rp        <= rp + 1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        fmem[wp[7:0]] = d;
        wp = wp + 1;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while ((log_q.size() < n) && (k < budget)) begin
            tick();
            k++;
        end
        check("wait_log_done", 64'(log_q.size() >= n), 64'(1));
    endtask

    task automatic check_log(input string tag, input logic [31:0] base, input int n,
                             input logic [7:0] lastmask);
        check({tag, "_count"}, 64'(log_q.size()), 64'(n));
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), 64'(log_q[i].b.data), 64'(base + 32'(i)));
            check($sformatf("%s_last%0d", tag, i), 64'(log_q[i].b.last), 64'(lastmask[i]));
        end
    endtask

    // Model: a word issued in cycle c is presentable from cycle c+2; in-order; every
    // accepted beat advances the burst position and total count.
    always @(negedge clk) begin
        int sz;
        bit ev, el, er, pop;
        cyc++;
        ev = 1'b0; el = 1'b0; er = 1'b0; pop = 1'b0;
        sz = q.size();
        if (rst) begin
            check("rd_en_in_rst", 64'(fifo_rd_en), 64'(0));
        end
        check("rd_en_while_empty", 64'(fifo_rd_en & fifo_empty), 64'(0));
        if (mdl_ok) begin
            if (sz > 0) ev = (q[0].cyc + 2 <= cyc);
            el  = ((pops % BL) == BL - 1);
            pop = ev && m_ready;
            er  = enable && !fifo_empty && !rst && ((sz - int'(pop)) < 2);
            check("m_valid", 64'(m_valid), 64'(ev));
            check("m_valid_bl1", 64'(m_valid1), 64'(ev));
            check("fifo_rd_en", 64'(fifo_rd_en), 64'(er));
            check("fifo_rd_en_bl1", 64'(fifo_rd_en1), 64'(er));
            check("beat_total", 64'(beat_total), 64'(pops));
            check("beat_total_bl1", 64'(beat_total1), 64'(pops));
            if (ev) begin
                check("m_data", 64'(m_data), 64'(q[0].data));
                check("m_last", 64'(m_last), 64'(el));
                check("m_data_bl1", 64'(m_data1), 64'(q[0].data));
                check("m_last_bl1", 64'(m_last1), 64'(1));
            end
        end
        if (rst) begin
            q.delete();
            pops   = 0;
            mdl_ok = 1'b1;
        end else if (mdl_ok) begin
            if (pop) begin
                log_q.push_back('{b: '{data: q[0].data, last: el}, cyc: cyc});
                void'(q.pop_front());
                pops++;
            end
            if (fifo_rd_en && !fifo_empty)
                q.push_back('{data: fmem[rp[7:0]], cyc: cyc});
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b1; m_ready = 1'b1; fifo_clr = 1'b0;

        // Reset held with data waiting, then straight streaming.
        for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
        repeat (3) tick();
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_m_last", 64'(m_last), 64'(0));
        check("rst_beat_total", 64'(beat_total), 64'(0));
        check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        #1;
        c0 = cyc;
        check("first_rd_en", 64'(fifo_rd_en), 64'(1));
        wait_log(8, 40);
        check_log("stream", 32'h10, 8, 8'h88);
        for (int i = 0; i < 8 && i < log_q.size(); i++)
            check($sformatf("stream_cyc%0d", i), 64'(log_q[i].cyc), 64'(c0 + 2 + i));
        check("stream_total", 64'(beat_total), 64'(8));

        // Backpressure with ready pattern 1,0,0,1.
        log_q.delete();
        for (int i = 0; i < 8; i++) push(32'h20 + 32'(i));
        for (int k = 0; k < 64 && log_q.size() < 8; k++) begin
            m_ready = pat[k % 4];
            tick();
        end
        m_ready = 1'b1;
        check_log("bp", 32'h20, 8, 8'h88);
        check("bp_total", 64'(beat_total), 64'(16));

        // Underflow mid-burst.
        log_q.delete();
        push(32'h30); push(32'h31);
        repeat (5) tick();
        check("gap_m_valid", 64'(m_valid), 64'(0));
        check("gap_rd_en", 64'(fifo_rd_en), 64'(0));
        push(32'h32); push(32'h33);
        wait_log(4, 20);
        check_log("uf", 32'h30, 4, 8'h08);

        // Disable after exactly three reads have been issued.
        log_q.delete();
        for (int i = 0; i < 8; i++) push(32'h40 + 32'(i));
        repeat (3) tick();
        enable = 1'b0;
        repeat (8) tick();
        check_log("en_off", 32'h40, 3, 8'h00);
        check("en_off_fifo_left", 64'(wp - rp), 64'(5));
        check("en_off_rd_en", 64'(fifo_rd_en), 64'(0));
        enable = 1'b1;
        wait_log(8, 30);
        check_log("en_on", 32'h40, 8, 8'h88);
        check("en_on_total", 64'(beat_total), 64'(28));

        // Reset after two beats of a burst; FIFO flushed alongside.
        log_q.delete();
        for (int i = 0; i < 8; i++) push(32'h50 + 32'(i));
        wait_log(2, 20);
        rst = 1'b1; fifo_clr = 1'b1;
        tick();
        rst = 1'b0; fifo_clr = 1'b0;
        check_log("pre_rst", 32'h50, 2, 8'h00);
        check("post_rst_total", 64'(beat_total), 64'(0));
        check("post_rst_valid", 64'(m_valid), 64'(0));
        log_q.delete();
        for (int i = 0; i < 4; i++) push(32'h60 + 32'(i));
        wait_log(4, 20);
        check_log("post_rst", 32'h60, 4, 8'h08);
        check("post_rst_total4", 64'(beat_total), 64'(4));

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
